// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle between a master (BFM or bench) and axi_mem_responder.
// Signal names match the flat port list of the original responder.
interface axi_mem_responder_if #(
   parameter int unsigned AXI_DATA_WIDTH = 64
);
   logic [31:0]                   axi_awaddr;
   logic [7:0]                    axi_awlen;
   logic [2:0]                    axi_awsize;
   logic [1:0]                    axi_awburst;
   logic [2:0]                    axi_awprot;
   logic [3:0]                    axi_awregion;
   logic [3:0]                    axi_awcache;
   logic [3:0]                    axi_awqos;
   logic                          axi_awvalid;
   logic                          axi_awready;
   logic [AXI_DATA_WIDTH-1:0]     axi_wdata;
   logic [AXI_DATA_WIDTH/8-1:0]   axi_wstrb;
   logic                          axi_wlast;
   logic                          axi_wvalid;
   logic                          axi_wready;
   logic [1:0]                    axi_bresp;
   logic                          axi_bvalid;
   logic                          axi_bready;
   logic [31:0]                   axi_araddr;
   logic [7:0]                    axi_arlen;
   logic [2:0]                    axi_arsize;
   logic [1:0]                    axi_arburst;
   logic [2:0]                    axi_arprot;
   logic [3:0]                    axi_arregion;
   logic [3:0]                    axi_arcache;
   logic [3:0]                    axi_arqos;
   logic                          axi_arvalid;
   logic                          axi_arready;
   logic [AXI_DATA_WIDTH-1:0]     axi_rdata;
   logic [1:0]                    axi_rresp;
   logic                          axi_rlast;
   logic                          axi_rvalid;
   logic                          axi_rready;

   modport master (
      output axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awprot, axi_awregion,
             axi_awcache, axi_awqos, axi_awvalid, axi_wdata, axi_wstrb, axi_wlast,
             axi_wvalid, axi_bready, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
             axi_arprot, axi_arregion, axi_arcache, axi_arqos, axi_arvalid, axi_rready,
      input  axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready, axi_rdata,
             axi_rresp, axi_rlast, axi_rvalid
   );

   modport slave (
      input  axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awprot, axi_awregion,
             axi_awcache, axi_awqos, axi_awvalid, axi_wdata, axi_wstrb, axi_wlast,
             axi_wvalid, axi_bready, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
             axi_arprot, axi_arregion, axi_arcache, axi_arqos, axi_arvalid, axi_rready,
      output axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready, axi_rdata,
             axi_rresp, axi_rlast, axi_rvalid
   );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a word-addressed register array; FIXED/INCR/WRAP bursts,
// independent write and read FSMs with one outstanding transaction each.
module axi_mem_responder #(
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned MEM_DEPTH      = 1024
) (
   input logic                axi_clk,
   input logic                rst,
   axi_mem_responder_if.slave axi
);
   localparam int unsigned NB = AXI_DATA_WIDTH / 8;
   localparam int unsigned B  = $clog2(NB);
   localparam int unsigned IW = $clog2(MEM_DEPTH);

   generate
      if (!(AXI_DATA_WIDTH == 64 || AXI_DATA_WIDTH == 128)) begin : g_bad_width
         $fatal(1, "axi_mem_responder: AXI_DATA_WIDTH must be 64 or 128");
      end
   endgenerate

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
   typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

   function automatic logic burst_err(logic [2:0] size, logic [1:0] burst, logic [7:0] len);
      return (size != 3'(B)) || (burst == 2'b11) ||
             (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
   endfunction

   // WRAP keeps the bits above the (len+1)-word window and wraps the bits inside it
   function automatic logic [IW-1:0] next_idx(logic [IW-1:0] idx, logic [7:0] len, logic [1:0] burst);
      logic [IW-1:0] mask;
      mask = IW'(len);
      case (burst)
         2'b00:   return idx;
         2'b10:   return (idx & ~mask) | ((idx + 1'b1) & mask);
         default: return idx + 1'b1;
      endcase
   endfunction

   logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   wstate_e                   wstate_q, wstate_d;
   logic [IW-1:0]             widx_q, widx_d;
   logic [7:0]                wlen_q, wlen_d, wbeat_q, wbeat_d;
   logic [1:0]                wburst_q, wburst_d, bresp_q, bresp_d;
   logic                      werr_q, werr_d, wlast_err_q, wlast_err_d;
   logic                      awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

   rstate_e                   rstate_q, rstate_d;
   logic [IW-1:0]             ridx_q, ridx_d;
   logic [7:0]                rlen_q, rlen_d, rbeat_q, rbeat_d;
   logic [1:0]                rburst_q, rburst_d, rresp_q, rresp_d;
   logic                      rerr_q, rerr_d, arready_q, arready_d;
   logic                      rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                      mem_we, w_final, w_last_bad, ar_err;
   logic [IW-1:0]             rnidx;

   always_comb begin
      wstate_d    = wstate_q;
      widx_d      = widx_q;
      wlen_d      = wlen_q;
      wbeat_d     = wbeat_q;
      wburst_d    = wburst_q;
      werr_d      = werr_q;
      wlast_err_d = wlast_err_q;
      awready_d   = awready_q;
      wready_d    = wready_q;
      bvalid_d    = bvalid_q;
      bresp_d     = bresp_q;
      mem_we      = 1'b0;
      w_final     = (wbeat_q == wlen_q);
      w_last_bad  = (axi.axi_wlast != w_final);
      case (wstate_q)
         W_IDLE: begin
            awready_d = 1'b1;
            if (axi.axi_awvalid && awready_q) begin
               widx_d      = axi.axi_awaddr[IW+B-1:B];
               wlen_d      = axi.axi_awlen;
               wburst_d    = axi.axi_awburst;
               werr_d      = burst_err(axi.axi_awsize, axi.axi_awburst, axi.axi_awlen);
               wbeat_d     = '0;
               wlast_err_d = 1'b0;
               awready_d   = 1'b0;
               wready_d    = 1'b1;
               wstate_d    = W_DATA;
            end
         end
         W_DATA: begin
            if (axi.axi_wvalid && wready_q) begin
               mem_we      = !werr_q && !rst;
               widx_d      = next_idx(widx_q, wlen_q, wburst_q);
               wbeat_d     = wbeat_q + 8'd1;
               wlast_err_d = wlast_err_q || w_last_bad;
               if (w_final) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bresp_d  = (werr_q || wlast_err_q || w_last_bad) ? 2'b10 : 2'b00;
                  wstate_d = W_RESP;
               end
            end
         end
         default: begin
            if (axi.axi_bready) begin
               bvalid_d  = 1'b0;
               bresp_d   = 2'b00;
               awready_d = 1'b1;
               wstate_d  = W_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      rstate_d  = rstate_q;
      ridx_d    = ridx_q;
      rlen_d    = rlen_q;
      rbeat_d   = rbeat_q;
      rburst_d  = rburst_q;
      rerr_d    = rerr_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      ar_err    = burst_err(axi.axi_arsize, axi.axi_arburst, axi.axi_arlen);
      rnidx     = next_idx(ridx_q, rlen_q, rburst_q);
      case (rstate_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (axi.axi_arvalid && arready_q) begin
               ridx_d    = axi.axi_araddr[IW+B-1:B];
               rlen_d    = axi.axi_arlen;
               rburst_d  = axi.axi_arburst;
               rerr_d    = ar_err;
               rbeat_d   = '0;
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rlast_d   = (axi.axi_arlen == 8'd0);
               rresp_d   = ar_err ? 2'b10 : 2'b00;
               rdata_d   = ar_err ? '0 : mem_q[axi.axi_araddr[IW+B-1:B]];
               rstate_d  = R_DATA;
            end
         end
         default: begin
            if (axi.axi_rready && rvalid_q) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  rresp_d   = 2'b00;
                  rdata_d   = '0;
                  arready_d = 1'b1;
                  rstate_d  = R_IDLE;
               end else begin
                  ridx_d  = rnidx;
                  rbeat_d = rbeat_q + 8'd1;
                  rlast_d = ((rbeat_q + 8'd1) == rlen_q);
                  rdata_d = rerr_q ? '0 : mem_q[rnidx];
               end
            end
         end
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (rst) begin
         wstate_q    <= W_IDLE;
         widx_q      <= '0;
         wlen_q      <= '0;
         wbeat_q     <= '0;
         wburst_q    <= '0;
         werr_q      <= 1'b0;
         wlast_err_q <= 1'b0;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= '0;
         rstate_q    <= R_IDLE;
         ridx_q      <= '0;
         rlen_q      <= '0;
         rbeat_q     <= '0;
         rburst_q    <= '0;
         rerr_q      <= 1'b0;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rlast_q     <= 1'b0;
         rresp_q     <= '0;
         rdata_q     <= '0;
      end else begin
         wstate_q    <= wstate_d;
         widx_q      <= widx_d;
         wlen_q      <= wlen_d;
         wbeat_q     <= wbeat_d;
         wburst_q    <= wburst_d;
         werr_q      <= werr_d;
         wlast_err_q <= wlast_err_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
         rstate_q    <= rstate_d;
         ridx_q      <= ridx_d;
         rlen_q      <= rlen_d;
         rbeat_q     <= rbeat_d;
         rburst_q    <= rburst_d;
         rerr_q      <= rerr_d;
         arready_q   <= arready_d;
         rvalid_q    <= rvalid_d;
         rlast_q     <= rlast_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
      end
   end

   // Storage is never reset; reads above sample it before this edge's write lands
   always_ff @(posedge axi_clk) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (axi.axi_wstrb[i]) mem_q[widx_q][8*i +: 8] <= axi.axi_wdata[8*i +: 8];
         end
      end
   end

   assign axi.axi_awready = awready_q;
   assign axi.axi_wready  = wready_q;
   assign axi.axi_bvalid  = bvalid_q;
   assign axi.axi_bresp   = bresp_q;
   assign axi.axi_arready = arready_q;
   assign axi.axi_rvalid  = rvalid_q;
   assign axi.axi_rdata   = rdata_q;
   assign axi.axi_rresp   = rresp_q;
   assign axi.axi_rlast   = rlast_q;

   logic unused_ok;
   assign unused_ok = ^{axi.axi_awprot, axi.axi_awregion, axi.axi_awcache, axi.axi_awqos,
                        axi.axi_arprot, axi.axi_arregion, axi.axi_arcache, axi.axi_arqos,
                        axi.axi_awaddr[B-1:0], axi.axi_awaddr[31:IW+B],
                        axi.axi_araddr[B-1:0], axi.axi_araddr[31:IW+B]};
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed and randomized bursts against axi_mem_responder, checked against a
// byte-address memory model kept in the bench.
module tb_axi_mem_responder;
   localparam int unsigned DW    = 64;
   localparam int unsigned NB    = DW / 8;
   localparam int unsigned DEPTH = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_mem_responder_if #(.AXI_DATA_WIDTH(DW)) axi ();

   axi_mem_responder #(.AXI_DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
      .axi_clk (clk),
      .rst     (rst),
      .axi     (axi)
   );

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] wdat [256];
   logic [NB-1:0] wstb [256];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_err(logic [2:0] size, logic [1:0] burst, int unsigned len);
      return (size != 3'd3) || (burst == 2'b11) ||
             (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
   endfunction

   // Byte address of each beat computed from AXI burst rules, then folded onto the array
   function automatic int unsigned word_of(logic [31:0] addr, int unsigned len, logic [1:0] burst,
                                           int unsigned beat);
      longint unsigned a, start, wsz, base;
      start = (longint'(addr) / NB) * NB;
      case (burst)
         2'b00: a = start;
         2'b10: begin
            wsz  = longint'(len + 1) * NB;
            base = (start / wsz) * wsz;
            a    = base + ((start - base + longint'(beat) * NB) % wsz);
         end
         default: a = start + longint'(beat) * NB;
      endcase
      return int'((a / NB) % DEPTH);
   endfunction

   task automatic wait_awready(input string tag);
      int n = 0;
      while (axi.axi_awready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_awready"}, axi.axi_awready, 1'b1);
   endtask

   task automatic wait_arready(input string tag);
      int n = 0;
      while (axi.axi_arready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_arready"}, axi.axi_arready, 1'b1);
   endtask

   task automatic do_write(input logic [31:0] addr, input int unsigned len, input logic [2:0] size,
                           input logic [1:0] burst, input bit bad_last, input string tag);
      bit err;
      int unsigned w;
      err = is_err(size, burst, len);
      axi.axi_awaddr  = addr;
      axi.axi_awlen   = 8'(len);
      axi.axi_awsize  = size;
      axi.axi_awburst = burst;
      axi.axi_awvalid = 1'b1;
      wait_awready(tag);
      @(posedge clk); #1;
      axi.axi_awvalid = 1'b0;
      chk({tag, "_wready"}, axi.axi_wready, 1'b1);
      for (int unsigned i = 0; i <= len; i++) begin
         axi.axi_wdata  = wdat[i];
         axi.axi_wstrb  = wstb[i];
         axi.axi_wlast  = !bad_last && (i == len);
         axi.axi_wvalid = 1'b1;
         @(posedge clk); #1;
         if (!err) begin
            w = word_of(addr, len, burst, i);
            for (int unsigned b = 0; b < NB; b++)
               if (wstb[i][b]) model[w][8*b +: 8] = wdat[i][8*b +: 8];
         end
      end
      axi.axi_wvalid = 1'b0;
      axi.axi_wlast  = 1'b0;
      chk({tag, "_bvalid"}, axi.axi_bvalid, 1'b1);
      @(posedge clk); #1;
      chk({tag, "_bvalid_hold"}, axi.axi_bvalid, 1'b1);
      chk({tag, "_bresp"}, axi.axi_bresp, (err || bad_last) ? 2'b10 : 2'b00);
      axi.axi_bready = 1'b1;
      @(posedge clk); #1;
      axi.axi_bready = 1'b0;
      chk({tag, "_bvalid_clr"}, axi.axi_bvalid, 1'b0);
      chk({tag, "_aw_again"}, axi.axi_awready, 1'b1);
   endtask

   task automatic do_read(input logic [31:0] addr, input int unsigned len, input logic [2:0] size,
                          input logic [1:0] burst, input int stall_beat, input int stall_cyc,
                          input string tag);
      bit err;
      logic [DW-1:0] exp;
      err = is_err(size, burst, len);
      axi.axi_araddr  = addr;
      axi.axi_arlen   = 8'(len);
      axi.axi_arsize  = size;
      axi.axi_arburst = burst;
      axi.axi_arvalid = 1'b1;
      wait_arready(tag);
      @(posedge clk); #1;
      axi.axi_arvalid = 1'b0;
      chk({tag, "_rvalid_lat"}, axi.axi_rvalid, 1'b1);
      for (int unsigned i = 0; i <= len; i++) begin
         exp = err ? '0 : model[word_of(addr, len, burst, i)];
         if (i == stall_beat) begin
            axi.axi_rready = 1'b0;
            for (int k = 0; k < stall_cyc; k++) begin
               @(posedge clk); #1;
               chk({tag, "_stall_rvalid"}, axi.axi_rvalid, 1'b1);
               chk({tag, "_stall_rdata"}, axi.axi_rdata, exp);
               chk({tag, "_stall_rlast"}, axi.axi_rlast, (i == len));
            end
         end
         axi.axi_rready = 1'b1;
         chk({tag, "_rvalid"}, axi.axi_rvalid, 1'b1);
         chk({tag, "_rdata"}, axi.axi_rdata, exp);
         chk({tag, "_rlast"}, axi.axi_rlast, (i == len));
         chk({tag, "_rresp"}, axi.axi_rresp, err ? 2'b10 : 2'b00);
         @(posedge clk); #1;
      end
      axi.axi_rready = 1'b0;
      chk({tag, "_rvalid_clr"}, axi.axi_rvalid, 1'b0);
      chk({tag, "_ar_again"}, axi.axi_arready, 1'b1);
   endtask

   initial begin
      logic [1:0]  burst;
      int unsigned len;
      logic [31:0] addr;
      logic [2:0]  size;

      axi.axi_awaddr = '0; axi.axi_awlen = '0; axi.axi_awsize = 3'd3; axi.axi_awburst = 2'b01;
      axi.axi_awprot = '0; axi.axi_awregion = '0; axi.axi_awcache = '0; axi.axi_awqos = '0;
      axi.axi_awvalid = 1'b0; axi.axi_wdata = '0; axi.axi_wstrb = '0; axi.axi_wlast = 1'b0;
      axi.axi_wvalid = 1'b0; axi.axi_bready = 1'b0;
      axi.axi_araddr = '0; axi.axi_arlen = '0; axi.axi_arsize = 3'd3; axi.axi_arburst = 2'b01;
      axi.axi_arprot = '0; axi.axi_arregion = '0; axi.axi_arcache = '0; axi.axi_arqos = '0;
      axi.axi_arvalid = 1'b0; axi.axi_rready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {axi.axi_awready, axi.axi_wready, axi.axi_bvalid, axi.axi_bresp,
                            axi.axi_arready, axi.axi_rvalid, axi.axi_rdata, axi.axi_rresp,
                            axi.axi_rlast}, '0);
      rst = 1'b0;

      // Clear the whole array with maximal 256-beat bursts
      for (int i = 0; i < 256; i++) begin wdat[i] = '0; wstb[i] = '1; end
      for (int unsigned k = 0; k < DEPTH / 256; k++)
         do_write(32'(k * 256 * NB), 255, 3'd3, 2'b01, 1'b0, "clear");

      wdat[0] = 64'h1122334455667788; wstb[0] = 8'hFF;
      do_write(32'h40, 0, 3'd3, 2'b01, 1'b0, "t1_wr");
      do_read(32'h40, 0, 3'd3, 2'b01, -1, 0, "t1_rd");

      for (int i = 0; i < 4; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      wdat[2] = '1; wstb[2] = 8'h0F;
      do_write(32'h100, 3, 3'd3, 2'b01, 1'b0, "t2_wr");
      do_read(32'h110, 0, 3'd3, 2'b01, -1, 0, "t2_rd");

      for (int i = 0; i < 4; i++) begin wdat[i] = 64'(i + 1); wstb[i] = 8'hFF; end
      do_write(32'h18, 3, 3'd3, 2'b10, 1'b0, "t3_wr");
      do_read(32'h0, 3, 3'd3, 2'b01, -1, 0, "t3_rd");

      for (int i = 0; i < 8; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      do_write(32'h200, 7, 3'd3, 2'b01, 1'b0, "t4_wr");
      do_read(32'h200, 7, 3'd3, 2'b01, 3, 3, "t4_rd");

      for (int i = 0; i < 2; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      do_write(32'h300, 1, 3'd3, 2'b11, 1'b0, "t5_wr");
      do_read(32'h300, 1, 3'd3, 2'b01, -1, 0, "t5_rd");
      do_read(32'h200, 2, 3'd3, 2'b10, -1, 0, "t5_wrap_rd");
      do_write(32'h340, 1, 3'd3, 2'b01, 1'b1, "wlast_wr");
      do_read(32'h340, 1, 3'd3, 2'b01, -1, 0, "wlast_rd");

      // Reset lands while beat 2 of an 8-beat write is on the bus
      for (int i = 0; i < 8; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      axi.axi_awaddr = 32'h1C00; axi.axi_awlen = 8'd7; axi.axi_awsize = 3'd3; axi.axi_awburst = 2'b01;
      axi.axi_awvalid = 1'b1;
      wait_awready("t6");
      @(posedge clk); #1;
      axi.axi_awvalid = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         axi.axi_wdata = wdat[i]; axi.axi_wstrb = wstb[i]; axi.axi_wlast = 1'b0; axi.axi_wvalid = 1'b1;
         if (i == 2) rst = 1'b1;
         @(posedge clk); #1;
         if (i < 2) model[word_of(32'h1C00, 7, 2'b01, i)] = wdat[i];
      end
      axi.axi_wvalid = 1'b0;
      chk("t6_reset_outputs", {axi.axi_awready, axi.axi_wready, axi.axi_bvalid, axi.axi_bresp,
                               axi.axi_arready, axi.axi_rvalid, axi.axi_rdata, axi.axi_rresp,
                               axi.axi_rlast}, '0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("t6_no_bvalid", axi.axi_bvalid, 1'b0);
      do_read(32'h1C00, 1, 3'd3, 2'b01, -1, 0, "t6_rd_kept");
      for (int i = 0; i < 2; i++) begin wdat[i] = {$urandom, $urandom}; wstb[i] = 8'hFF; end
      do_write(32'h1E00, 1, 3'd3, 2'b01, 1'b0, "t6_wr");
      do_read(32'h1E00, 1, 3'd3, 2'b01, -1, 0, "t6_rd");

      for (int it = 0; it < 20; it++) begin
         burst = 2'($urandom_range(0, 2));
         case (burst)
            2'b00:   len = $urandom_range(0, 3);
            2'b10:   len = (2 << $urandom_range(0, 3)) - 1;
            default: len = $urandom_range(0, 15);
         endcase
         addr = $urandom;
         size = (it % 5 == 4) ? 3'd2 : 3'd3;
         for (int unsigned i = 0; i <= len; i++) begin
            wdat[i] = {$urandom, $urandom};
            wstb[i] = 8'($urandom);
         end
         do_write(addr, len, size, burst, 1'b0, "rnd_wr");
         do_read(addr, len, 3'd3, burst, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "rnd_rd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
